encryption_block: RTL
=====================

// Module: encryption_block
// PURPOSE
//  Iterative AES-128 encryptor, one round per clock. Write-path counterpart of DecryptionBlock:
//  the SD-card write path encrypts each 128-bit block with this module before it goes to the card.
//  Decryption recovers it with the same key_in.
//  Round keys are expanded on the fly, one per cycle. No key schedule storage.
// PARAMETERS
//  NUM_ROUNDS   10   AES round count; 10 is the only legal value (AES-128).
// PORTS
//  clk             in   1    system clock, all state updates on rising edge
//  rst             in   1    asynchronous, active-high reset
//  enable_encrypt  in   1    start request; sampled only while idle
//  data_in         in   128  plaintext block; [127:120] = state byte 0 (column-major, FIPS-197)
//  key_in          in   128  cipher key, same byte order as data_in
//  final_data_out  out  128  ciphertext of the last completed operation, held until the next completion
//  enc_busy        out  1    high while an operation is in progress
//  enc_done        out  1    one-cycle pulse when final_data_out updates
// BEHAVIOUR
//  Reset (async, active-high):
//   - final_data_out=0, enc_busy=0, enc_done=0.
//   - state, round key and round counter cleared; FSM to IDLE.
//   - Reset mid-operation aborts the operation; no enc_done is produced.
//  FSM states:
//   - IDLE:
//     - If enable_encrypt=1 at edge E:
//       - state <= data_in ^ key_in
//       - rkey <= key_in
//       - rnd <= 1
//       - enc_busy <= 1
//       - go to ROUND.
//     - data_in and key_in are sampled only at E. They may change freely afterwards.
//   - ROUND:
//     - nk = KeyExpand(rkey, rcon[rnd]), where rcon = 01,02,04,08,10,20,40,80,1b,36.
//     - Each edge: state <= MixColumns(ShiftRows(SubBytes(state))) ^ nk; rkey <= nk; rnd <= rnd+1.
//     - On rnd==NUM_ROUNDS, MixColumns is skipped. The result goes to final_data_out.
//     - On that same edge: enc_done <= 1, enc_busy <= 0, go to IDLE.
//   - No separate DONE state. enc_done is 1 for exactly the cycle after edge E+10.
//  Timing:
//   - Latency: start accepted at edge E; ciphertext valid and enc_done high after edge E+10.
//   - enc_busy is high from after E through edge E+10, i.e. 10 cycles.
//  Handshake:
//   - enable_encrypt while enc_busy=1 is ignored. It is not queued.
//   - enable_encrypt held high continuously: a new operation starts on the edge after enc_done rises.
//     That is the first IDLE cycle, so back-to-back throughput is one block per 11 cycles.
//   - Level or pulse start are equivalent.
//  Output hold:
//   - final_data_out changes only on a completion edge or on reset.
//   - It is stable while the next operation runs.
//  Arithmetic:
//   - SubBytes: combinational S-box function (GF(2^8) inverse, x^254 mod 0x11b, then the FIPS-197 affine transform).
//   - S-box instance count: 16 for state + 4 for key (RotWord/SubWord).
//   - MixColumns uses xtime: (b<<1) ^ (b[7] ? 8'h1b : 0). All byte math is mod 2^8, XOR only.
//  Round counter: 4 bits, range 1..10, never wraps past NUM_ROUNDS.
// TESTING
//  1. FIPS-197 C.1 vector:
//     - Stimulus: pulse enable_encrypt with data_in=00112233445566778899aabbccddeeff, key_in=000102030405060708090a0b0c0d0e0f.
//     - Required: final_data_out=69c4e0d86a7b0430d8cdb78070b4c55a; enc_done one cycle, 10 edges after acceptance.
//  2. FIPS-197 App. B vector:
//     - Stimulus: data_in=3243f6a8885a308d313198a2e0370734, key_in=2b7e151628aed2a6abf7158809cf4f3c.
//     - Required: final_data_out=3925841d02dc09fbdc118597196a0b32; enc_busy high exactly 10 cycles.
//  3. Busy-ignore:
//     - Stimulus: re-pulse enable_encrypt with new data at round 4 of scenario 1.
//     - Required: ciphertext still 69c4e0d8...; no second enc_done; enc_busy falls once.
//  4. Reset mid-op:
//     - Stimulus: assert rst at round 6.
//     - Required: outputs 0 at once (async), no enc_done.
//     - Follow-up: a fresh start after rst deassert gives the correct scenario-2 result.
//  5. Round trip:
//     - Stimulus: encrypt random block P with key K, then feed the result to DecryptionBlock with K.
//     - Required: the DecryptionBlock output equals P. Cover 20 random P/K pairs.
//  6. Continuous enable:
//     - Stimulus: hold enable_encrypt=1, change data_in after each enc_done.
//     - Required: one enc_done every 11 cycles, each result correct; final_data_out stable between pulses.

Source files
------------

// File: rtl/encryption_block.sv
// Iterative AES-128 encryptor: one round per clock, round key expanded on the fly.
// The start edge loads the initial AddRoundKey; ten ROUND edges then finish the block.
module encryption_block #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable_encrypt,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic [127:0] final_data_out,
    output logic         enc_busy,
    output logic         enc_done
);

    typedef enum logic {IDLE, ROUND} fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rkey_q, rkey_d;
    logic [127:0] final_q, final_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [127:0] nk;
    logic [127:0] ss;
    logic [127:0] mc;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Byte i of the state sits at [127-8i -: 8]; row r, column c is byte r+4c.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    always_comb begin
        nk = key_expand(rkey_q, rcon(rnd_q));
        ss = sub_shift(st_q);
        mc = mix_columns(ss);

        fsm_d   = fsm_q;
        st_d    = st_q;
        rkey_d  = rkey_q;
        final_d = final_q;
        rnd_d   = rnd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (fsm_q)
            IDLE: begin
                if (enable_encrypt) begin
                    st_d   = data_in ^ key_in;
                    rkey_d = key_in;
                    rnd_d  = 4'd1;
                    busy_d = 1'b1;
                    fsm_d  = ROUND;
                end
            end
            ROUND: begin
                rkey_d = nk;
                if (rnd_q == 4'(NUM_ROUNDS)) begin
                    final_d = ss ^ nk;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    fsm_d   = IDLE;
                end else begin
                    st_d  = mc ^ nk;
                    rnd_d = rnd_q + 4'd1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            st_q    <= '0;
            rkey_q  <= '0;
            final_q <= '0;
            rnd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            st_q    <= st_d;
            rkey_q  <= rkey_d;
            final_q <= final_d;
            rnd_q   <= rnd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign final_data_out = final_q;
    assign enc_busy       = busy_q;
    assign enc_done       = done_q;

endmodule
